// File: rtl/tt_um_hoene_pwm_pkg.sv
// Shared defaults and the phase-offset helper for the multi-channel LED PWM.
package tt_um_hoene_pwm_pkg;

  localparam int DEF_CHANNELS = 3;
  localparam int DEF_WIDTH    = 10;
  localparam int DEF_STAGGER  = 1;

  // Evenly spreads channel phases across one counter period.
  function automatic int off(input int i, input int channels, input int width);
    return (i * (1 << width)) / channels;
  endfunction

endpackage

// File: rtl/tt_um_hoene_pwm_channel.sv
// One PWM channel: shadow/active duty pair and the phase comparator.
module tt_um_hoene_pwm_channel #(
  parameter int WIDTH  = 10,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             capture_i,
  input  logic             apply_i,
  output logic             out_o
);

  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             out_q, out_d;
  logic [WIDTH-1:0] phase;

  // Offset addition wraps naturally in WIDTH bits.
  assign phase = cnt_i + OFF;

  // Next-state: capture into shadow, promote to active only at the wrap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (capture_i) shadow_d = duty_i;
    if (apply_i)   active_d = shadow_q;
    out_d = (phase < active_q);
  end

  // Duty registers and the registered PWM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      out_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/tt_um_hoene_led_pwm_multi.sv
// Multi-channel LED PWM: shared counter, double-buffered duty load handshake.
module tt_um_hoene_led_pwm_multi
  import tt_um_hoene_pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STAGGER  = DEF_STAGGER
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             period_start_q, period_start_d;
  logic             wrap;
  logic             accept;
  logic             apply;

  assign wrap       = &cnt_q;
  assign load_ready = ~pending_q;
  assign accept     = load_valid & ~pending_q;
  // accept and apply are mutually exclusive since they need opposite pending.
  assign apply      = wrap & pending_q;

  // Next-state for counter, pending flag and period marker.
  always_comb begin
    cnt_d          = cnt_q + WIDTH'(1);
    pending_d      = pending_q;
    if (accept)     pending_d = 1'b1;
    else if (apply) pending_d = 1'b0;
    period_start_d = (cnt_q == '0);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int OFFS = (STAGGER != 0) ? off(i, CHANNELS, WIDTH) : 0;
    tt_um_hoene_pwm_channel #(
      .WIDTH  (WIDTH),
      .OFFSET (OFFS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt_i     (cnt_q),
      .duty_i    (duty_in[i*WIDTH +: WIDTH]),
      .capture_i (accept),
      .apply_i   (apply),
      .out_o     (out[i])
    );
  end

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_multi.sv
// Scoreboard bench: aligned (STAGGER=0) and staggered (STAGGER=1) instances, WIDTH=4, CHANNELS=3.
module tb_tt_um_hoene_led_pwm_multi;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int P  = 16;

  logic          clk;
  logic          rst;
  logic [11:0]   duty_in;
  logic          load_valid;
  logic          rdy0, rdy1, ps0, ps1;
  logic [2:0]    out0, out1;

  tt_um_hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .STAGGER(0)) u0 (
    .clk(clk), .rst(rst), .duty_in(duty_in), .load_valid(load_valid),
    .load_ready(rdy0), .out(out0), .period_start(ps0));

  tt_um_hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .STAGGER(1)) u1 (
    .clk(clk), .rst(rst), .duty_in(duty_in), .load_valid(load_valid),
    .load_ready(rdy1), .out(out1), .period_start(ps1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int       e;
    logic [2:0] o0;
    logic [2:0] o1;
    logic     ps;
    logic     rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: list of accepted loads and the period each becomes active in.
  int          acc_edge[$];
  int          acc_per[$];
  logic [11:0] acc_duty[$];

  bit [2:0] hist0[1024];
  bit [2:0] hist1[1024];

  int          sched_e[$];
  logic [11:0] sched_d[$];
  bit          rand_mode;

  task automatic chk(input string name, input int e, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, e, act, req);
    end
  endtask

  // Pending after edge e: some load accepted at or before e whose wrap edge is still ahead.
  function automatic bit pend_after(input int e);
    for (int k = 0; k < acc_edge.size(); k++)
      if (acc_edge[k] <= e && e < acc_per[k] * P - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int active_duty(input int p, input int ch);
    int d = 0;
    logic [11:0] v;
    for (int k = 0; k < acc_per.size(); k++)
      if (acc_per[k] <= p) begin
        v = acc_duty[k];
        d = int'(v[ch*4 +: 4]);
      end
    return d;
  endfunction

  function automatic logic [2:0] exp_out(input int e, input bit stagger);
    logic [2:0] r;
    int c = e % P;
    int p = e / P;
    for (int ch = 0; ch < CH; ch++) begin
      int o = stagger ? (ch * P) / CH : 0;
      r[ch] = (((c + o) % P) < active_duty(p, ch));
    end
    return r;
  endfunction

  function automatic int highs(input int inst, input int ch, input int p);
    int s = 0;
    bit [2:0] v;
    for (int e = p * P; e < p * P + P; e++) begin
      v = (inst != 0) ? hist1[e] : hist0[e];
      s += int'(v[ch]);
    end
    return s;
  endfunction

  function automatic int first_rise(input int inst, input int ch, input int from, input int to);
    bit [2:0] a, b;
    for (int e = from; e <= to; e++) begin
      a = (inst != 0) ? hist1[e]   : hist0[e];
      b = (inst != 0) ? hist1[e-1] : hist0[e-1];
      if (a[ch] && !b[ch]) return e;
    end
    return -1000;
  endfunction

  // Monitor: one expected item per clock edge after release.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("out_aligned",    x.e, int'(out0), int'(x.o0));
        chk("out_staggered",  x.e, int'(out1), int'(x.o1));
        chk("period_start",   x.e, int'({ps1, ps0}), int'({x.ps, x.ps}));
        chk("load_ready",     x.e, int'({rdy1, rdy0}), int'({x.rdy, x.rdy}));
        hist0[x.e] = out0;
        hist1[x.e] = out1;
      end
    end
  end

  // Called at a negedge (or mid-cycle); releases reset at a negedge with a fresh model.
  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    acc_edge.delete();
    acc_per.delete();
    acc_duty.delete();
    for (int i = 0; i < 1024; i++) begin
      hist0[i] = '0;
      hist1[i] = '0;
    end
    rst = 1'b0;
  endtask

  // Drives n edges starting at edge 0 after release, pushing expectations.
  task automatic run(input int n);
    exp_t x;
    bit   v;
    logic [11:0] d;
    for (int e = 0; e < n; e++) begin
      v = 1'b0;
      d = 12'(e * 7);
      if (rand_mode) begin
        v = ($urandom_range(0, 3) == 0);
        d = 12'($urandom_range(0, 4095));
      end else begin
        for (int k = 0; k < sched_e.size(); k++)
          if (sched_e[k] == e) begin
            v = 1'b1;
            d = sched_d[k];
          end
      end
      load_valid = v;
      duty_in    = d;
      if (v && !pend_after(e - 1)) begin
        acc_edge.push_back(e);
        acc_per.push_back((e + 1) / P + 1);
        acc_duty.push_back(d);
      end
      x.e   = e;
      x.o0  = exp_out(e, 1'b0);
      x.o1  = exp_out(e, 1'b1);
      x.ps  = ((e % P) == 0);
      x.rdy = !pend_after(e);
      exp_q.push_back(x);
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic scenario(input int n);
    do_reset();
    run(n);
    sched_e.delete();
    sched_d.delete();
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    duty_in    = '0;
    rand_mode  = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_out",   -1, int'({out1, out0}), 0);
    chk("reset_ps",    -1, int'({ps1, ps0}), 0);
    chk("reset_ready", -1, int'({rdy1, rdy0}), 3);

    // Aligned load {5,0,15}
    sched_e.push_back(0); sched_d.push_back(12'hF05);
    scenario(48);
    for (int p = 1; p <= 2; p++) begin
      chk("s0_ch0_highs", p, highs(0, 0, p), 5);
      chk("s0_ch1_highs", p, highs(0, 1, p), 0);
      chk("s0_ch2_highs", p, highs(0, 2, p), 15);
      chk("s1_ch2_highs", p, highs(1, 2, p), 15);
    end

    // All duties 4: stagger lag between channel 0 and 1
    sched_e.push_back(0); sched_d.push_back(12'h444);
    scenario(48);
    chk("stagger_lag", 16, (first_rise(1, 1, 16, 47) - first_rise(1, 0, 16, 47) + 32) % P, 11);
    chk("aligned_lag", 16, (first_rise(0, 1, 16, 47) - first_rise(0, 0, 16, 47) + 32) % P, 0);

    // Load at cnt=7 then ignored second load at cnt=9
    sched_e.push_back(23); sched_d.push_back(12'h9A6);
    sched_e.push_back(25); sched_d.push_back(12'h123);
    scenario(64);
    chk("pend_p1_ch0", 1, highs(0, 0, 1), 0);
    chk("pend_p2_ch0", 2, highs(0, 0, 2), 6);
    chk("pend_p3_ch1", 3, highs(0, 1, 3), 10);

    // Load accepted on the wrap edge
    sched_e.push_back(0);  sched_d.push_back(12'h666);
    sched_e.push_back(31); sched_d.push_back(12'hBBB);
    scenario(64);
    chk("wrap_p2_old", 2, highs(0, 0, 2), 6);
    chk("wrap_p3_new", 3, highs(0, 0, 3), 11);

    // Duty 12 -> 3 mid-period, no runt
    sched_e.push_back(0);  sched_d.push_back(12'hCCC);
    sched_e.push_back(24); sched_d.push_back(12'h333);
    scenario(48);
    chk("chg_p1_12", 1, highs(0, 0, 1), 12);
    chk("chg_p2_3",  2, highs(0, 0, 2), 3);
    chk("chg_p2_shape", 32, int'({hist0[35][0], hist0[34][0], hist0[33][0], hist0[32][0]}), 7);

    // Reset pulsed at cnt=6 with out[0]=1 and a pending set
    sched_e.push_back(0);  sched_d.push_back(12'hAAA);
    sched_e.push_back(20); sched_d.push_back(12'h777);
    scenario(22);
    chk("pre_rst_out0",  21, int'(out0[0]), 1);
    chk("pre_rst_ready", 21, int'(rdy0), 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_now",   22, int'({out1, out0}), 0);
    chk("rst_ready_now", 22, int'({rdy1, rdy0}), 3);
    chk("rst_ps_now",    22, int'({ps1, ps0}), 0);
    scenario(34);
    chk("post_rst_p1", 1, highs(0, 0, 1) + highs(1, 2, 1), 0);

    // Randomized loads
    rand_mode = 1'b1;
    scenario(400);
    rand_mode = 1'b0;

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drain", -1, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
